mem_arbiter_rr: RTL

//  Parametrised N-channel arbiter in front of the single-port frame/command RAM.

---
 rtl/mem_arbiter_rr.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   N-channel round-robin arbiter in front of the single-port frame/command RAM.
//   One rts/rtr transfer is granted per cycle and registered onto the RAM port
//   at the next edge. Read data returns on a shared broadcast bus with a
//   one-hot channel tag, RD_LAT+1 cycles after issue.
//
// Configuration macro:
//   ARB_FETCH_PRIO_EN  defined   -> ch0 (data fetcher) has strict priority and
//                                   does not advance the RR pointer.
//                      undefined -> ch0 takes part in plain round-robin.
//
// Ports:
//   clk, rst_        clock (rising edge), asynchronous active-low reset
//   en_fetching      0 masks ch0 from arbitration
//   req_rts_in       per-channel ready-to-send
//   req_rtr_out      per-channel ready-to-receive (one-hot grant or 0)
//   req_op           per-channel byte-write enables, 4'b0000 = read
//   req_addr         per-channel address, ch i at [i*ADDR_W +: ADDR_W]
//   req_wrdata       per-channel write data
//   wben             RAM byte write enables
//   mem_addr         RAM address
//   mem_data_out     RAM write data
//   mem_data_in      RAM read data
//   bcast_data       broadcast read data (held until next return)
//   bcast_xfc_out    one-hot read-return strobe
module mem_arbiter_rr #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     en_fetching,
    input  logic [NUM_CH-1:0]        req_rts_in,
    output logic [NUM_CH-1:0]        req_rtr_out,
    input  logic [NUM_CH*4-1:0]      req_op,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wrdata,
    output logic [3:0]               wben,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data_out,
    input  logic [DATA_W-1:0]        mem_data_in,
    output logic [DATA_W-1:0]        bcast_data,
    output logic [NUM_CH-1:0]        bcast_xfc_out
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] gnt_vec;
    logic [PTR_W-1:0]  hi_idx;
    logic [PTR_W-1:0]  lo_idx;
    logic [PTR_W-1:0]  gnt_idx;
    logic              hi_found;
    logic              lo_found;
    logic              gnt_found;
    logic              prio_hit;
    logic [3:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [NUM_CH-1:0] tag_q [0:RD_LAT];

    // Round-robin search split into two passes: the first eligible channel at
    // or above the pointer wins; otherwise the first eligible one below it.
    // This equals a wrapped search starting at ptr without a modulo.
    always_comb begin
        elig     = req_rts_in;
        elig[0]  = req_rts_in[0] & en_fetching;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (elig[i]) begin
                if (i >= 32'(ptr)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = PTR_W'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = PTR_W'(i);
                end
            end
        end

        prio_hit = 1'b0;
`ifdef ARB_FETCH_PRIO_EN
        prio_hit = elig[0];
`endif

        gnt_found = prio_hit | hi_found | lo_found;
        if (prio_hit) begin
            gnt_idx = '0;
        end else if (hi_found) begin
            gnt_idx = hi_idx;
        end else begin
            gnt_idx = lo_idx;
        end
        gnt_vec = gnt_found ? (NUM_CH'(1) << gnt_idx) : '0;
    end

    // A priority grant to ch0 leaves the pointer where it was.
    always_comb begin
        ptr_nxt = ptr;
        if (gnt_found && !prio_hit) begin
            ptr_nxt = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                sel_op    = req_op[i*4 +: 4];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wrdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant is withheld while reset is asserted so no requester sees a
    // handshake that the register stage would discard.
    assign req_rtr_out = rst_ ? gnt_vec : '0;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr          <= '0;
            wben         <= '0;
            mem_addr     <= '0;
            mem_data_out <= '0;
        end else begin
            ptr  <= ptr_nxt;
            wben <= gnt_found ? sel_op : 4'b0000;
            if (gnt_found) begin
                mem_addr <= sel_addr;
                if (sel_op != 4'b0000) begin
                    mem_data_out <= sel_wdata;
                end
            end
        end
    end

    // tag_q[0] is aligned with the issue cycle; tag_q[RD_LAT] with the cycle in
    // which mem_data_in holds that read's data, which is then captured.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int unsigned k = 0; k <= RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
            bcast_xfc_out <= '0;
            bcast_data    <= '0;
        end else begin
            tag_q[0] <= (gnt_found && sel_op == 4'b0000) ? gnt_vec : '0;
            for (int unsigned k = 1; k <= RD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            bcast_xfc_out <= tag_q[RD_LAT];
            if (|tag_q[RD_LAT]) begin
                bcast_data <= mem_data_in;
            end
        end
    end

endmodule
